// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and default widths for the data-memory load/store sequencer
package dm_pkg;

    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 16;
    localparam int DM_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } dm_state_t;

endpackage

// File: rtl/dm_if.sv
// rtl/dm_if.sv - command, store, load and memory-port signals of the load/store sequencer
interface dm_if import dm_pkg::*; #(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int LEN_W  = DM_LEN_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_offset;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic              busy;
    logic              done;

    logic              mem_wflag;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_base, cmd_offset, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output busy, done,
        output mem_wflag, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_base, cmd_offset, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  busy, done,
        input  mem_wflag, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_rd_buf.sv
// rtl/dm_rd_buf.sv - one-entry registered output buffer for load words
module dm_rd_buf import dm_pkg::*; #(
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              cap_en
);

    // A new word may be captured when the slot is empty or is being drained this cycle.
    assign cap_en = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dm_master.sv
// rtl/dm_master.sv - load/store sequencer driving the data-memory port in single or burst mode
module dm_master import dm_pkg::*; #(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int LEN_W  = DM_LEN_W
) (
    input  logic clk,
    input  logic rst,
    dm_if.master bus
);

    dm_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  cnt;
    logic              done_q;
    logic              done_set;
    logic              cmd_ready;
    logic              wr_ready;
    logic              mem_wflag;
    logic              capture;
    logic              cap_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              cmd_hs;
    logic              wr_hs;

    assign cmd_hs = cmd_ready && bus.cmd_valid;
    assign wr_hs  = wr_ready && bus.wr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_wflag = 1'b0;
        capture   = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                // Gating with rst keeps an abandoned burst from committing a word in the reset cycle.
                wr_ready  = ~rst;
                mem_wflag = bus.wr_valid & ~rst;
                if (bus.wr_valid && cnt == '0) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            READ: begin
                capture = cap_en;
                if (cap_en && cnt == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_valid && bus.rd_ready) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_set;
            if (cmd_hs) begin
                addr <= bus.cmd_base + bus.cmd_offset;
                cnt  <= bus.cmd_len;
            end else if (wr_hs || capture) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt - LEN_W'(1);
            end
        end
    end

    dm_rd_buf #(.DATA_W(DATA_W)) u_rd_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .din     (bus.mem_rdata),
        .ready   (bus.rd_ready),
        .valid   (rd_valid),
        .data    (rd_data),
        .cap_en  (cap_en)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_data;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_wflag = mem_wflag;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = bus.wr_data;

endmodule

// File: doc/dm_master.md
# dm_master

Load/store sequencer for the 16-bit custom processor: the initiator side of the data-memory port. Accepts single or burst (1–16 word) load/store commands from the execute stage and computes the effective address as base + offset. Streams store data into the memory's write-flag/address/data inputs and streams load data out through a registered valid/ready port. Sits between the datapath and the data memory.

## Interface
- ADDR_W, 16, address width; the effective address wraps modulo 2^ADDR_W.
- DATA_W, 16, data word width.
- LEN_W, 4, width of the burst length field; a burst is 1..2^LEN_W words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both valid and ready are high; high only in IDLE.
- cmd_write  in  1  1 = store burst, 0 = load burst.
- cmd_base  in  ADDR_W  base address.
- cmd_offset  in  ADDR_W  offset added to base.
- cmd_len  in  LEN_W  burst length minus 1.
- wr_valid  in  1  store word offered.
- wr_ready  out  1  store word accepted; high only in WRITE and not in reset.
- wr_data  in  DATA_W  store word.
- rd_valid  out  1  load word available (registered).
- rd_ready  in  1  consumer accepts the load word.
- rd_data  out  DATA_W  load word (registered).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle registered pulse at burst completion.
- mem_wflag  out  1  memory write flag.
- mem_addr  out  ADDR_W  memory address; driven from the address register.
- mem_wdata  out  DATA_W  memory write data; equals wr_data.
- mem_rdata  in  DATA_W  combinational memory read data; valid while mem_wflag = 0.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: on cmd handshake, latch addr = (cmd_base + cmd_offset) mod 2^16 (carry discarded) and cnt = cmd_len. Go to WRITE if cmd_write = 1, else READ.
- WRITE: mem_wflag = wr_valid & ~rst, combinational. Each wr handshake writes one word at mem_addr; the memory commits it on the next edge. Then addr++ (0xFFFF wraps to 0x0000) and cnt--. The handshake with cnt = 0 sets done and returns to IDLE.
- READ: mem_wflag = 0. Capture is enabled when !rd_valid || rd_ready. On capture: rd_data <= mem_rdata, rd_valid <= 1, addr++, cnt--. A capture with cnt = 0 moves to DRAIN. While capture is blocked, addr and cnt hold.
- DRAIN: no memory access. On rd handshake, clear rd_valid, set done, return to IDLE.
- READ handshake without a new capture clears rd_valid.
- mem_wflag is 0 in IDLE, READ, DRAIN and during rst. It never asserts for a read cycle.
- cmd_* inputs are ignored outside IDLE. wr_valid is ignored outside WRITE.
- Reset values: state IDLE, addr 0, cnt 0, rd_valid 0, rd_data 0, done 0, busy 0, mem_wflag 0.
- Reset mid-burst: the burst is abandoned and no done pulse is produced. Words already written stay in memory. A pending rd_data is discarded.

## Timing
- Command accepted in cycle T: first memory access in T+1.
- Store of N words with wr_valid held high: mem_wflag high T+1..T+N, done high at T+N+1, cmd_ready high at T+N+1.
- Load of N words with rd_ready held high: rd_valid high T+2..T+N+1, one word per cycle; done at T+N+2.
- Throughput is one word per cycle in both directions when unstalled. rd_ready low stalls address advance with no word loss or duplication.
- A back-to-back command is accepted in the same cycle done is high.

## Structure
- Shared package dm_pkg: state enum (IDLE, WRITE, READ, DRAIN), ADDR_W/DATA_W/LEN_W defaults.
- One sub-module, dm_rd_buf: one-entry registered valid/ready output buffer holding rd_data/rd_valid, with a capture-enable output. Everything else stays in dm_master.

## Test plan
- Single store: base 0x1000, offset 0x0010, len 0, wr_data 0xABCD → one mem_wflag cycle at mem_addr 0x1010; done one cycle later; a following load of 0x1010 returns 0xABCD.
- Store burst with wrap: base 0xFFFE, offset 0, len 3, data 1,2,3,4 → writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; 4-word load readback matches in order.
- Load burst with backpressure: len 7, rd_ready toggling 1/0 → exactly 8 words delivered in order, no duplicates; addr holds while stalled; done after 8th handshake.
- Store stall: wr_valid low for 3 cycles mid-burst → mem_wflag low in those cycles, addr unchanged; total 4 writes for len 3.
- Reset mid-burst: rst high in 3rd cycle of a len 7 store with wr_valid high → mem_wflag 0 in the rst cycle; only 2 words written; state IDLE; no done pulse.
- Offset overflow and back-to-back: base 0xF000 + offset 0x2000 → addr 0x1000; a new command accepted in the done cycle starts its access on the next cycle.
